// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - captures a staggered ROWS x COLS result tile and drains it row-major
module systolic_result_collector #(
  parameter int COLS    = 2,
  parameter int ROWS    = 2,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COLS-1:0]        pe_valid,
  input  logic [COLS*DATA_W-1:0] pe_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int CNT_W = $clog2(ROWS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int WORDS = ROWS * COLS;
  localparam int K_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt [COLS];
  logic [TMO_W-1:0]          tmo_cnt;
  logic [K_W-1:0]            rd_idx;
  // Tile stored row-major: word k = r*COLS + c lives at [k*DATA_W +: DATA_W]
  logic [WORDS*DATA_W-1:0]   tile_flat;

  logic [COLS-1:0]           lane_take;
  logic [COLS-1:0]           lane_full_nxt;
  logic                      any_drop;

  // Per-lane capture decision and whether each lane is full after this edge
  always_comb begin
    lane_take     = '0;
    lane_full_nxt = '0;
    any_drop      = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      lane_take[c]     = pe_valid[c] && (cnt[c] < CNT_W'(ROWS));
      lane_full_nxt[c] = (cnt[c] == CNT_W'(ROWS)) ||
                         (lane_take[c] && (cnt[c] == CNT_W'(ROWS - 1)));
      if (pe_valid[c] && !lane_take[c]) any_drop = 1'b1;
    end
  end

  // Buffer is only read while draining, when no writes can occur, so the word is stall-stable
  assign out_data = out_valid ? tile_flat[int'(rd_idx)*DATA_W +: DATA_W] : '0;

  // Control FSM with registered status outputs; also performs the tile captures
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int c = 0; c < COLS; c++) cnt[c] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_COLLECT;
            busy    <= 1'b1;
            err     <= 1'b0;
            tmo_cnt <= '0;
            for (int c = 0; c < COLS; c++) cnt[c] <= '0;
          end
        end
        S_COLLECT: begin
          for (int c = 0; c < COLS; c++) begin
            if (lane_take[c]) begin
              tile_flat[(int'(cnt[c])*COLS + c)*DATA_W +: DATA_W] <= pe_data[c*DATA_W +: DATA_W];
              cnt[c] <= cnt[c] + 1'b1;
            end
          end
          if (any_drop) err <= 1'b1;
          // A tile completing on the final allowed cycle still drains
          if (&lane_full_nxt) begin
            state     <= S_DRAIN;
            out_valid <= 1'b1;
            out_last  <= (WORDS == 1);
            rd_idx    <= '0;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (|pe_valid) err <= 1'b1;
          if (out_ready) begin
            if (out_last) begin
              state     <= S_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              rd_idx   <= rd_idx + 1'b1;
              out_last <= (int'(rd_idx) == WORDS - 2);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb/tb_systolic_result_collector.sv - randomized and directed bench for systolic_result_collector
module tb_systolic_result_collector;
  localparam int COLS = 2;
  localparam int ROWS = 2;
  localparam int DW   = 16;
  localparam int TMO  = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [COLS-1:0]    pe_valid = '0;
  logic [COLS*DW-1:0] pe_data = '0;
  logic               out_ready = 1'b0;
  logic               out_valid, out_last, busy, done, err;
  logic [DW-1:0]      out_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_valid = 0;
  int rdy_mode = 0;
  int cyc = 0;
  logic [DW-1:0] got[$];

  systolic_result_collector #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .pe_valid(pe_valid), .pe_data(pe_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: per-lane arrival queues, then a row-major output queue
  int            m_phase = 0;  // 0 idle, 1 collecting, 2 streaming, 3 done pulse
  logic [DW-1:0] m_lane [COLS][$];
  logic [DW-1:0] m_stream[$];
  int            m_wait = 0;
  bit            m_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_err = 1'b0; m_wait = 0;
      m_stream.delete();
      for (int c = 0; c < COLS; c++) m_lane[c].delete();
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_err = 1'b0; m_wait = 0;
          for (int c = 0; c < COLS; c++) m_lane[c].delete();
        end
        1: begin
          bit full;
          full = 1'b1;
          for (int c = 0; c < COLS; c++)
            if (pe_valid[c]) begin
              if (m_lane[c].size() < ROWS) m_lane[c].push_back(pe_data[c*DW +: DW]);
              else m_err = 1'b1;
            end
          for (int c = 0; c < COLS; c++) if (m_lane[c].size() != ROWS) full = 1'b0;
          if (full) begin
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++) m_stream.push_back(m_lane[c][r]);
            m_phase = 2;
          end else begin
            m_wait++;
            if (m_wait >= TMO) begin m_err = 1'b1; m_phase = 0; end
          end
        end
        2: begin
          if (|pe_valid) m_err = 1'b1;
          if (out_ready) begin
            void'(m_stream.pop_front());
            if (m_stream.size() == 0) m_phase = 3;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Single compare process, sampled mid-cycle
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    chk("done", 32'(done), 32'(m_phase == 3));
    chk("err", 32'(err), 32'(m_err));
    chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
    if (m_phase == 2 && m_stream.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(m_stream[0]));
      chk("out_last", 32'(out_last), 32'(m_stream.size() == 1));
    end
    if (!rst && out_valid && out_ready) got.push_back(out_data);
    if (done) n_done++;
    if (out_valid) n_valid++;
  end

  // out_ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = random
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = (cyc % 3 == 0);
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_pe(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    pe_valid = v;
    pe_data  = {d1, d0};
    step();
    pe_valid = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while ((busy || done) && n < budget) begin step(); n++; end
    chk({nm, "_finished"}, 32'(busy || done), 32'(0));
  endtask

  task automatic check_tile(input string nm, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    chk({nm, "_count"}, got.size(), 4);
    if (got.size() == 4) begin
      chk({nm, "_w0"}, 32'(got[0]), 32'(e0));
      chk({nm, "_w1"}, 32'(got[1]), 32'(e1));
      chk({nm, "_w2"}, 32'(got[2]), 32'(e2));
      chk({nm, "_w3"}, 32'(got[3]), 32'(e3));
    end
  endtask

  initial begin
    int nb, n;
    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    step();

    // Staggered arrival, always ready
    rdy_mode = 0; got.delete(); n_done = 0;
    do_start();
    drive_pe(2'b01, 16'h00A0, 16'h0000);
    drive_pe(2'b11, 16'h00A1, 16'h00B0);
    drive_pe(2'b10, 16'h0000, 16'h00B1);
    wait_idle(40, "t1");
    check_tile("t1", 16'h00A0, 16'h00B0, 16'h00A1, 16'h00B1);
    chk("t1_done_count", n_done, 1);

    // Backpressure
    rdy_mode = 1; got.delete(); n_done = 0;
    do_start();
    drive_pe(2'b01, 16'h00A0, 16'h0000);
    drive_pe(2'b11, 16'h00A1, 16'h00B0);
    drive_pe(2'b10, 16'h0000, 16'h00B1);
    wait_idle(60, "t2");
    check_tile("t2", 16'h00A0, 16'h00B0, 16'h00A1, 16'h00B1);
    chk("t2_done_count", n_done, 1);

    // Overflow on lane 0; err persists until next accepted start
    rdy_mode = 0; got.delete(); n_done = 0;
    do_start();
    drive_pe(2'b01, 16'h1110, 16'h0000);
    drive_pe(2'b01, 16'h1111, 16'h0000);
    drive_pe(2'b01, 16'h11EE, 16'h0000);
    drive_pe(2'b10, 16'h0000, 16'h2220);
    drive_pe(2'b10, 16'h0000, 16'h2221);
    wait_idle(40, "t3");
    check_tile("t3", 16'h1110, 16'h2220, 16'h1111, 16'h2221);
    chk("t3_err_sticky", 32'(err), 1);
    step();
    chk("t3_err_idle", 32'(err), 1);
    do_start();
    chk("t3_err_cleared", 32'(err), 0);
    drive_pe(2'b11, 16'h0001, 16'h0002);
    drive_pe(2'b11, 16'h0003, 16'h0004);
    wait_idle(40, "t3b");

    // Timeout: only lane 0 delivers
    got.delete(); n_done = 0; n_valid = 0;
    do_start();
    nb = 0; n = 0;
    while (busy && n < 200) begin
      nb++;
      pe_valid = (n < 2) ? 2'b01 : 2'b00;
      pe_data  = {16'h0000, 16'(16'h3000 + n)};
      step();
      n++;
    end
    pe_valid = '0;
    chk("t4_busy_cycles", nb, 64);
    chk("t4_err", 32'(err), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_no_valid", n_valid, 0);
    chk("t4_no_done", n_done, 0);

    // Reset mid-drain, then a fresh tile
    got.delete(); n_done = 0; rdy_mode = 0;
    do_start();
    drive_pe(2'b11, 16'h4440, 16'h5550);
    drive_pe(2'b11, 16'h4441, 16'h5551);
    n = 0;
    while (got.size() < 2 && n < 20) begin step(); n++; end
    chk("t5_two_handshakes", got.size(), 2);
    rst = 1'b1;
    step();
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_err", 32'(err), 0);
    rst = 1'b0;
    step();
    got.delete(); n_done = 0;
    do_start();
    drive_pe(2'b10, 16'h0000, 16'h6660);
    drive_pe(2'b01, 16'h7770, 16'h0000);
    drive_pe(2'b11, 16'h7771, 16'h6661);
    wait_idle(40, "t5");
    check_tile("t5", 16'h7770, 16'h6660, 16'h7771, 16'h6661);
    chk("t5_done_count", n_done, 1);

    // Ignored events: pe_valid in idle, start held through collect
    got.delete(); n_done = 0;
    drive_pe(2'b11, 16'hDEAD, 16'hBEEF);
    drive_pe(2'b11, 16'hDEAD, 16'hBEEF);
    do_start();
    start = 1'b1;
    drive_pe(2'b11, 16'h8880, 16'h9990);
    drive_pe(2'b11, 16'h8881, 16'h9991);
    start = 1'b0;
    wait_idle(40, "t6");
    check_tile("t6", 16'h8880, 16'h9990, 16'h8881, 16'h9991);
    chk("t6_done_count", n_done, 1);

    // Randomized traffic checked by the model
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 5) == 0);
      pe_valid = COLS'($urandom_range(0, 3));
      pe_data  = {16'($urandom), 16'($urandom)};
      rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    start = 1'b0; pe_valid = '0; rst = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
